// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; one op in flight.
// Optional overflow trap on add/sub results is enabled by defining ALU_ARB_OVTRAP_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [2:0]       req_ctr0,
    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_ctr1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             resp_valid0,
    input  logic             resp_ready0,
    output logic             resp_valid1,
    input  logic             resp_ready1,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_ovf,
    output logic             resp_zero,
    output logic             resp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             owner;
    logic [WIDTH-1:0] op_a, op_b;
    logic [2:0]       op_ctr;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf, res_zero, res_err;
    logic             gnt_id;
    logic             accept;
    logic             trap;

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        gnt_id = req_valid1;
        if (req_valid0 && req_valid1)
            gnt_id = ~last_grant;
    end

`ifdef ALU_ARB_OVTRAP_EN
    assign trap = alu_overflow && ((op_ctr == 3'b001) || (op_ctr == 3'b101));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        req_ready0  = 1'b0;
        req_ready1  = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctr     = 3'b000;
        resp_valid0 = 1'b0;
        resp_valid1 = 1'b0;
        case (state)
            IDLE: begin
                // Ready is suppressed while reset is held so every output reads 0.
                if ((req_valid0 || req_valid1) && !rst) begin
                    accept     = 1'b1;
                    req_ready0 = ~gnt_id;
                    req_ready1 = gnt_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                alu_a     = op_a;
                alu_b     = op_b;
                alu_ctr   = op_ctr;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid0 = ~owner;
                resp_valid1 = owner;
                if (owner ? resp_ready1 : resp_ready0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= gnt_id;
                last_grant <= gnt_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_ctr   <= 3'b000;
            res_data <= '0;
            res_ovf  <= 1'b0;
            res_zero <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= gnt_id ? req_a1   : req_a0;
                op_b   <= gnt_id ? req_b1   : req_b0;
                op_ctr <= gnt_id ? req_ctr1 : req_ctr0;
            end
            if (state == EXEC) begin
                res_data <= trap ? '0 : alu_result;
                res_ovf  <= alu_overflow;
                res_zero <= alu_zero;
                res_err  <= trap;
            end
        end
    end

    assign resp_data = res_data;
    assign resp_ovf  = res_ovf;
    assign resp_zero = res_zero;
    assign resp_err  = res_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the shared port.
// Expectations for the add-overflow case follow ALU_ARB_OVTRAP_EN.
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid0, req_ready0, req_valid1, req_ready1;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]   req_ctr0, req_ctr1;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctr;
    logic         alu_overflow, alu_zero;
    logic         resp_valid0, resp_ready0, resp_valid1, resp_ready1;
    logic [W-1:0] resp_data;
    logic         resp_ovf, resp_zero, resp_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(req_valid0), .req_ready0(req_ready0),
        .req_a0(req_a0), .req_b0(req_b0), .req_ctr0(req_ctr0),
        .req_valid1(req_valid1), .req_ready1(req_ready1),
        .req_a1(req_a1), .req_b1(req_b1), .req_ctr1(req_ctr1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .resp_valid0(resp_valid0), .resp_ready0(resp_ready0),
        .resp_valid1(resp_valid1), .resp_ready1(resp_ready1),
        .resp_data(resp_data), .resp_ovf(resp_ovf), .resp_zero(resp_zero), .resp_err(resp_err)
    );

    // Behavioural ALU: 000 addu, 001 add, 010 and, 011 unused (0), 100 subu, 101 sub, 110 or, 111 slt
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_ctr)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'b010: alu_result = alu_a & alu_b;
            3'b100: alu_result = alu_a - alu_b;
            3'b101: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'b110: alu_result = alu_a | alu_b;
            3'b111: alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic idle_inputs();
        req_valid0 = 1'b0; req_a0 = '0; req_b0 = '0; req_ctr0 = 3'b000;
        req_valid1 = 1'b0; req_a1 = '0; req_b1 = '0; req_ctr1 = 3'b000;
        resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({req_ready0, req_ready1, alu_a, alu_b, alu_ctr, resp_valid0, resp_valid1,
             resp_data, resp_ovf, resp_zero, resp_err} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got ready=%b%b alu_a=%h alu_ctr=%b rv=%b%b data=%h flags=%b%b%b exp all 0",
                     req_ready0, req_ready1, alu_a, alu_ctr, resp_valid0, resp_valid1,
                     resp_data, resp_ovf, resp_zero, resp_err);
        end
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_valid0 = 1'b1; req_a0 = 32'd5; req_b0 = 32'd3; req_ctr0 = 3'b000;
        #1;
        compared++; if (req_ready0 !== 1'b1) begin mismatched++; $display("FAIL t1_ready0 got=%b exp=1", req_ready0); end
        compared++; if (req_ready1 !== 1'b0) begin mismatched++; $display("FAIL t1_ready1 got=%b exp=0", req_ready1); end
        @(negedge clk); #1;
        req_valid0 = 1'b0;
        #1;
        compared++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin mismatched++; $display("FAIL t1_alu_ops got=%h,%h exp=5,3", alu_a, alu_b); end
        compared++; if (alu_ctr !== 3'b000) begin mismatched++; $display("FAIL t1_alu_ctr got=%b exp=000", alu_ctr); end
        compared++; if (req_ready0 !== 1'b0) begin mismatched++; $display("FAIL t1_ready0_exec got=%b exp=0", req_ready0); end
        @(negedge clk); #1;
        compared++; if (resp_valid0 !== 1'b1 || resp_valid1 !== 1'b0) begin mismatched++; $display("FAIL t1_resp_valid got=%b%b exp=10", resp_valid0, resp_valid1); end
        compared++; if (resp_data !== 32'd8) begin mismatched++; $display("FAIL t1_data got=%h exp=8", resp_data); end
        compared++; if ({resp_ovf, resp_zero, resp_err} !== 3'b000) begin mismatched++; $display("FAIL t1_flags got=%b%b%b exp=000", resp_ovf, resp_zero, resp_err); end
        resp_ready0 = 1'b1;
        @(negedge clk); #1;
        compared++; if (resp_valid0 !== 1'b0) begin mismatched++; $display("FAIL t1_resp_done got=%b exp=0", resp_valid0); end
        resp_ready0 = 1'b0;
    endtask

    task automatic test_alternate();
        int  n;
        int  both;
        logic grants [0:7];
        apply_reset();
        n = 0; both = 0;
        req_valid0 = 1'b1; req_a0 = 32'd10; req_b0 = 32'd1; req_ctr0 = 3'b000;
        req_valid1 = 1'b1; req_a1 = 32'd20; req_b1 = 32'd2; req_ctr1 = 3'b100;
        resp_ready0 = 1'b1; resp_ready1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready0 && req_ready1) both++;
            if (req_ready0) begin grants[n] = 1'b0; n++; end
            else if (req_ready1) begin grants[n] = 1'b1; n++; end
            if (resp_valid0) begin
                compared++; if (resp_data !== 32'd11) begin mismatched++; $display("FAIL t2_data0 got=%h exp=b", resp_data); end
            end
            if (resp_valid1) begin
                compared++; if (resp_data !== 32'd18) begin mismatched++; $display("FAIL t2_data1 got=%h exp=12", resp_data); end
            end
            @(negedge clk);
        end
        idle_inputs();
        compared++; if (both !== 0) begin mismatched++; $display("FAIL t2_both_ready got=%0d exp=0", both); end
        compared++; if (n !== 4) begin mismatched++; $display("FAIL t2_grant_count got=%0d exp=4", n); end
        if (n == 4) begin
            compared++;
            if ({grants[0], grants[1], grants[2], grants[3]} !== 4'b0101) begin
                mismatched++;
                $display("FAIL t2_grant_order got=%b%b%b%b exp=0101", grants[0], grants[1], grants[2], grants[3]);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        req_valid0 = 1'b1; req_a0 = 32'd100; req_b0 = 32'd23; req_ctr0 = 3'b000;
        #1;
        compared++; if (req_ready0 !== 1'b1) begin mismatched++; $display("FAIL t3_ready0 got=%b exp=1", req_ready0); end
        @(negedge clk); #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b1; req_a1 = 32'd1; req_b1 = 32'd1; req_ctr1 = 3'b000;
        resp_ready0 = 1'b0; resp_ready1 = 1'b1;
        @(negedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            compared++; if (resp_valid0 !== 1'b1 || resp_valid1 !== 1'b0) begin mismatched++; $display("FAIL t3_hold_valid c=%0d got=%b%b exp=10", c, resp_valid0, resp_valid1); end
            compared++; if (resp_data !== 32'd123) begin mismatched++; $display("FAIL t3_hold_data c=%0d got=%h exp=7b", c, resp_data); end
            compared++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin mismatched++; $display("FAIL t3_hold_ready c=%0d got=%b%b exp=00", c, req_ready0, req_ready1); end
            @(negedge clk); #1;
        end
        resp_ready0 = 1'b1;
        @(negedge clk); #1;
        compared++; if (resp_valid0 !== 1'b0) begin mismatched++; $display("FAIL t3_released got=%b exp=0", resp_valid0); end
        compared++; if (req_ready1 !== 1'b1) begin mismatched++; $display("FAIL t3_next_grant got=%b exp=1", req_ready1); end
        idle_inputs();
        @(negedge clk); #1;
    endtask

    task automatic test_overflow();
        req_valid0 = 1'b1; req_a0 = 32'h7FFF_FFFF; req_b0 = 32'd1; req_ctr0 = 3'b001;
        @(negedge clk); #1;
        req_valid0 = 1'b0;
        compared++; if (alu_ctr !== 3'b001) begin mismatched++; $display("FAIL t4_alu_ctr got=%b exp=001", alu_ctr); end
        @(negedge clk); #1;
        compared++; if (resp_valid0 !== 1'b1) begin mismatched++; $display("FAIL t4_resp_valid got=%b exp=1", resp_valid0); end
        compared++; if (resp_ovf !== 1'b1) begin mismatched++; $display("FAIL t4_ovf got=%b exp=1", resp_ovf); end
`ifdef ALU_ARB_OVTRAP_EN
        compared++; if (resp_data !== 32'h0 || resp_err !== 1'b1) begin mismatched++; $display("FAIL t4_trap got=%h err=%b exp=0 err=1", resp_data, resp_err); end
`else
        compared++; if (resp_data !== 32'h8000_0000 || resp_err !== 1'b0) begin mismatched++; $display("FAIL t4_trap got=%h err=%b exp=80000000 err=0", resp_data, resp_err); end
`endif
        resp_ready0 = 1'b1;
        @(negedge clk); #1;
        resp_ready0 = 1'b0;
        // A non-overflowing sub must never raise the trap.
        req_valid1 = 1'b1; req_a1 = 32'd5; req_b1 = 32'd3; req_ctr1 = 3'b101;
        @(negedge clk); #1;
        req_valid1 = 1'b0;
        @(negedge clk); #1;
        compared++; if (resp_valid1 !== 1'b1 || resp_data !== 32'd2) begin mismatched++; $display("FAIL t4_sub got v=%b d=%h exp v=1 d=2", resp_valid1, resp_data); end
        compared++; if (resp_err !== 1'b0 || resp_ovf !== 1'b0) begin mismatched++; $display("FAIL t4_sub_flags got err=%b ovf=%b exp 0 0", resp_err, resp_ovf); end
        resp_ready1 = 1'b1;
        @(negedge clk); #1;
        resp_ready1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid0 = 1'b1; req_a0 = 32'd1; req_b0 = 32'd2; req_ctr0 = 3'b000;
        @(negedge clk); #1;
        req_valid0 = 1'b0; resp_ready0 = 1'b1;
        @(negedge clk); #1;
        compared++; if (resp_data !== 32'd3) begin mismatched++; $display("FAIL t5_pre_data got=%h exp=3", resp_data); end
        @(negedge clk); #1;
        resp_ready0 = 1'b0;
        req_valid0 = 1'b1; req_a0 = 32'd9; req_b0 = 32'd4; req_ctr0 = 3'b001;
        @(negedge clk); #1;
        req_valid0 = 1'b0; req_valid1 = 1'b1;
        #1;
        compared++; if (alu_a !== 32'd9 || alu_ctr !== 3'b001) begin mismatched++; $display("FAIL t5_exec got a=%h ctr=%b exp a=9 ctr=001", alu_a, alu_ctr); end
        rst = 1'b1;
        #1;
        compared++; if (alu_a !== '0 || alu_b !== '0 || alu_ctr !== 3'b000) begin mismatched++; $display("FAIL t5_alu_cleared got a=%h b=%h ctr=%b exp 0", alu_a, alu_b, alu_ctr); end
        compared++; if (resp_data !== '0 || resp_valid0 !== 1'b0) begin mismatched++; $display("FAIL t5_resp_cleared got d=%h v=%b exp 0", resp_data, resp_valid0); end
        compared++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin mismatched++; $display("FAIL t5_ready_in_reset got=%b%b exp=00", req_ready0, req_ready1); end
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        #1;
        compared++; if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin mismatched++; $display("FAIL t5_tie_after_reset got=%b%b exp=10", req_ready0, req_ready1); end
        idle_inputs();
        @(negedge clk); #1;
    endtask

    task automatic test_slt_req1();
        req_valid1 = 1'b1; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_ctr1 = 3'b111;
        #1;
        compared++; if (req_ready1 !== 1'b1 || req_ready0 !== 1'b0) begin mismatched++; $display("FAIL t6_ready got=%b%b exp=01", req_ready0, req_ready1); end
        @(negedge clk); #1;
        req_valid1 = 1'b0;
        compared++; if (alu_ctr !== 3'b111 || alu_a !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL t6_alu got ctr=%b a=%h exp 111 ffffffff", alu_ctr, alu_a); end
        @(negedge clk); #1;
        resp_ready0 = 1'b1;
        compared++; if (resp_valid1 !== 1'b1 || resp_valid0 !== 1'b0) begin mismatched++; $display("FAIL t6_resp_valid got=%b%b exp=01", resp_valid0, resp_valid1); end
        compared++; if (resp_data !== 32'd1) begin mismatched++; $display("FAIL t6_data got=%h exp=1", resp_data); end
        @(negedge clk); #1;
        compared++; if (resp_valid1 !== 1'b1) begin mismatched++; $display("FAIL t6_nonowner_ready got=%b exp=1", resp_valid1); end
        resp_ready0 = 1'b0; resp_ready1 = 1'b1;
        @(negedge clk); #1;
        compared++; if (resp_valid1 !== 1'b0) begin mismatched++; $display("FAIL t6_done got=%b exp=0", resp_valid1); end
        resp_ready1 = 1'b0;
    endtask

    task automatic test_unused_ctr();
        req_valid0 = 1'b1; req_a0 = 32'hA; req_b0 = 32'hB; req_ctr0 = 3'b011;
        @(negedge clk); #1;
        req_valid0 = 1'b0;
        compared++; if (alu_ctr !== 3'b011) begin mismatched++; $display("FAIL t7_ctr_pass got=%b exp=011", alu_ctr); end
        @(negedge clk); #1;
        compared++; if (resp_data !== 32'd0 || resp_zero !== 1'b1) begin mismatched++; $display("FAIL t7_zero got d=%h z=%b exp d=0 z=1", resp_data, resp_zero); end
        resp_ready0 = 1'b1;
        @(negedge clk); #1;
        resp_ready0 = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_slt_req1();
        test_unused_ctr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "bench timed out");
    end

endmodule
